// File: rtl/spi_sck_generator_if.sv
// rtl/spi_sck_generator_if.sv - control/status bundle between SPI master datapath and SCK generator
interface spi_sck_generator_if #(
    parameter int DIV_WIDTH     = 8,
    parameter int BIT_CNT_WIDTH = 5
);
    logic                     start;
    logic                     abort;
    logic [DIV_WIDTH-1:0]     div;
    logic [BIT_CNT_WIDTH-1:0] num_bits;
    logic                     cpol;
    logic                     cpha;
    logic                     sck;
    logic                     sample_strb;
    logic                     shift_strb;
    logic                     busy;
    logic                     done;

    modport master (
        output start, abort, div, num_bits, cpol, cpha,
        input  sck, sample_strb, shift_strb, busy, done
    );

    modport slave (
        input  start, abort, div, num_bits, cpol, cpha,
        output sck, sample_strb, shift_strb, busy, done
    );
endinterface

// File: rtl/spi_sck_generator.sv
// rtl/spi_sck_generator.sv - programmable SPI SCK generator with CPOL/CPHA strobes and N-bit bursts
module spi_sck_generator #(
    parameter int DIV_WIDTH     = 8,
    parameter int BIT_CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_sck_generator_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0]     r_cnt, w_cnt_nxt;
    logic [BIT_CNT_WIDTH:0]   r_edge, w_edge_nxt;
    logic [BIT_CNT_WIDTH:0]   w_edge_inc;
    logic [DIV_WIDTH-1:0]     r_div_q, w_div_q_nxt;
    logic [BIT_CNT_WIDTH-1:0] r_nbits_q, w_nbits_q_nxt;
    logic                     r_cpol_q, w_cpol_q_nxt;
    logic                     r_cpha_q, w_cpha_q_nxt;
    logic                     r_sck, w_sck_nxt;
    logic                     r_sample, w_sample_nxt;
    logic                     r_shift, w_shift_nxt;
    logic                     r_busy, w_busy_nxt;
    logic                     r_done, w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_div_q   <= '0;
            r_nbits_q <= '0;
            r_cpol_q  <= 1'b0;
            r_cpha_q  <= 1'b0;
            r_sck     <= 1'b0;
            r_sample  <= 1'b0;
            r_shift   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_edge    <= w_edge_nxt;
            r_div_q   <= w_div_q_nxt;
            r_nbits_q <= w_nbits_q_nxt;
            r_cpol_q  <= w_cpol_q_nxt;
            r_cpha_q  <= w_cpha_q_nxt;
            r_sck     <= w_sck_nxt;
            r_sample  <= w_sample_nxt;
            r_shift   <= w_shift_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign w_edge_inc = r_edge + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_edge_nxt    = r_edge;
        w_div_q_nxt   = r_div_q;
        w_nbits_q_nxt = r_nbits_q;
        w_cpol_q_nxt  = r_cpol_q;
        w_cpha_q_nxt  = r_cpha_q;
        w_sck_nxt     = r_sck;
        w_sample_nxt  = 1'b0;
        w_shift_nxt   = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sck_nxt = bus.cpol;
                if (bus.start && (bus.num_bits != '0)) begin
                    w_div_q_nxt   = bus.div;
                    w_nbits_q_nxt = bus.num_bits;
                    w_cpol_q_nxt  = bus.cpol;
                    w_cpha_q_nxt  = bus.cpha;
                    w_cnt_nxt     = '0;
                    w_edge_nxt    = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_sck_nxt   = r_cpol_q;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == r_div_q) begin
                    w_cnt_nxt  = '0;
                    w_sck_nxt  = ~r_sck;
                    w_edge_nxt = w_edge_inc;
                    // Odd edge numbers are leading edges; CPHA picks which strobe they carry.
                    if (w_edge_inc[0] != r_cpha_q)
                        w_sample_nxt = 1'b1;
                    else
                        w_shift_nxt = 1'b1;
                    if (w_edge_inc == {r_nbits_q, 1'b0})
                        w_state_nxt = ST_TAIL;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_TAIL: begin
                if (bus.abort) begin
                    w_sck_nxt   = r_cpol_q;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == r_div_q) begin
                    w_cnt_nxt   = '0;
                    w_edge_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_sck_nxt   = r_cpol_q;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.sck         = r_sck;
    assign bus.sample_strb = r_sample;
    assign bus.shift_strb  = r_shift;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_spi_sck_generator.sv
// tb/tb_spi_sck_generator.sv - scoreboard bench for spi_sck_generator edge/strobe/done timing
module tb_spi_sck_generator;
    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    typedef struct {
        int       cyc;
        logic [2:0] kind;
        logic     sck;
    } ev_t;

    ev_t exp_q[$];

    spi_sck_generator_if #(.DIV_WIDTH(8), .BIT_CNT_WIDTH(5)) bus ();

    spi_sck_generator #(.DIV_WIDTH(8), .BIT_CNT_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Event codes are {done, shift_strb, sample_strb}.
    always @(negedge clk) begin
        if (!rst) begin
            logic [2:0] code;
            ev_t        e;
            code = {bus.done, bus.shift_strb, bus.sample_strb};
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missed_event_cycle", 32'(cyc), 32'(e.cyc));
            end
            if (code != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(code), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_cycle", 32'(cyc), 32'(e.cyc));
                    check("evt_kind", 32'(code), 32'(e.kind));
                    check("evt_sck", 32'(bus.sck), 32'(e.sck));
                end
            end
        end
    end

    task automatic push_xfer(input int t0, input int d, input int n, input logic cpol,
                             input logic cpha, input int abort_at);
        ev_t e;
        logic lead;
        for (int k = 1; k <= 2 * n; k++) begin
            e.cyc = t0 + k * (d + 1);
            if (abort_at >= 0 && e.cyc >= abort_at) return;
            lead   = (k % 2) == 1;
            e.kind = (lead != cpha) ? 3'b001 : 3'b010;
            e.sck  = cpol ^ lead;
            exp_q.push_back(e);
        end
        if (abort_at < 0) begin
            e.cyc  = t0 + (2 * n + 1) * (d + 1);
            e.kind = 3'b100;
            e.sck  = cpol;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input int d, input int n, input logic cpol, input logic cpha);
        bus.div      = 8'(d);
        bus.num_bits = 5'(n);
        bus.cpol     = cpol;
        bus.cpha     = cpha;
    endtask

    task automatic start_xfer(input int d, input int n, input logic cpol, input logic cpha,
                              input int abort_at_rel, output int t0);
        drive(d, n, cpol, cpha);
        bus.start = 1'b1;
        t0 = cyc + 1;
        push_xfer(t0, d, n, cpol, cpha, (abort_at_rel >= 0) ? t0 + abort_at_rel : -1);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_quiet(input int limit);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || bus.busy) && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (i >= limit) check("timeout", 32'd1, 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        drive(0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(bus.sck), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_strobes", 32'({bus.sample_strb, bus.shift_strb}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, div 3, 8 bits.
        start_xfer(3, 8, 1'b0, 1'b0, -1, t0);
        wait_quiet(200);
        check("mode0_idle_sck", 32'(bus.sck), 32'd0);

        // Mode 3, div 0, 4 bits.
        drive(0, 4, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("mode3_idle_sck", 32'(bus.sck), 32'd1);
        start_xfer(0, 4, 1'b1, 1'b1, -1, t0);
        wait_quiet(50);
        @(negedge clk);
        check("mode3_after_sck", 32'(bus.sck), 32'd1);

        // num_bits = 0 is ignored.
        drive(2, 0, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("nbits0_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("nbits0_busy_later", 32'(bus.busy), 32'd0);

        // Start while busy is ignored and input changes do not leak in.
        start_xfer(2, 3, 1'b0, 1'b1, -1, t0);
        repeat (4) @(negedge clk);
        drive(0, 7, 1'b1, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_quiet(100);

        // Abort mid-RUN at T0+10.
        start_xfer(3, 8, 1'b0, 1'b0, 10, t0);
        while (cyc < t0 + 9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sck", 32'(bus.sck), 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_events", 32'(exp_q.size()), 32'd0);
        start_xfer(0, 1, 1'b0, 1'b1, -1, t0);
        wait_quiet(20);

        // Back-to-back with start held high.
        drive(1, 2, 1'b0, 1'b0);
        bus.start = 1'b1;
        t0 = cyc + 1;
        t1 = t0 + 11;
        push_xfer(t0, 1, 2, 1'b0, 1'b0, -1);
        push_xfer(t1, 1, 2, 1'b0, 1'b0, -1);
        while (cyc < t1 && cyc < t0 + 50) @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy_second", 32'(bus.busy), 32'd1);
        wait_quiet(50);

        // Maximum divisor and bit count.
        start_xfer(255, 31, 1'b0, 1'b0, -1, t0);
        wait_quiet(17000);

        // Reset mid-RUN, then cpol reflected one cycle after release.
        start_xfer(1, 4, 1'b1, 1'b0, -1, t0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_sck", 32'(bus.sck), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_outs", 32'({bus.done, bus.sample_strb, bus.shift_strb}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cpol", 32'(bus.sck), 32'd1);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_sck_generator.md
# spi_sck_generator

Programmable SPI serial-clock generator for the SPI master datapath. It replaces the fixed power-of-two tap divider with an arbitrary integer half-period divider, CPOL/CPHA mode support, and a bounded burst of N bit-periods per transfer. It emits single-cycle sample/shift strobes aligned to SCK edges so the shift register can run entirely in the `clk` domain.

## Interface
- `DIV_WIDTH`, 8, width of the half-period divisor.
- `BIT_CNT_WIDTH`, 5, width of the bits-per-transfer field; max transfer is 2^BIT_CNT_WIDTH − 1 bits.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: transfer request; accepted only when `busy`=0.
- `abort` in 1: synchronous cancel of an active transfer.
- `div` in DIV_WIDTH: SCK half-period minus 1, in `clk` cycles; latched on accept.
- `num_bits` in BIT_CNT_WIDTH: bit-periods per transfer; latched on accept; 0 means request ignored.
- `cpol` in 1: SCK idle level; latched on accept.
- `cpha` in 1: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing; latched on accept.
- `sck` out 1: serial clock, registered.
- `sample_strb` out 1: one-cycle pulse in the cycle `sck` takes a sample edge value.
- `shift_strb` out 1: one-cycle pulse in the cycle `sck` takes a shift edge value.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, RUN, TAIL.
- IDLE: `sck` <= `cpol` every cycle, so the line tracks the mode before a transfer. `start`=1 and `num_bits`≠0: latch `div`/`num_bits`/`cpol`/`cpha`, clear the half-period counter and edge counter, set `busy`, go to RUN. `start` with `num_bits`=0 is ignored.
- RUN: the half-period counter increments each cycle. When it equals `div_q`:
  - counter clears, `sck` toggles, edge counter increments.
  - Odd-numbered edges (1, 3, …) are leading; even-numbered edges are trailing.
  - Leading edge: `sample_strb` if `cpha_q`=0, otherwise `shift_strb`.
  - Trailing edge: the opposite strobe.
  - When the edge counter reaches 2·`num_bits_q`, go to TAIL; `sck` is then back at `cpol_q`.
- TAIL: hold `sck`=`cpol_q` for `div_q`+1 cycles (CS-deassert margin). At the end: `busy` <= 0 and `done` <= 1 on the same edge, go to IDLE.
- `abort`=1 in RUN or TAIL: on the next edge go to IDLE, `sck` <= `cpol_q`, `busy` <= 0, no strobes, no `done`. `abort` in IDLE has no effect. `abort` has priority over the edge logic in the same cycle.
- `start` while `busy`=1 is ignored; it is not queued.
- Changes to `div`, `cpol`, `cpha` or `num_bits` while busy have no effect until the next accept.
- Edge counter width is BIT_CNT_WIDTH+1; it cannot overflow.

## Timing
- Reset values: `sck`=0, `busy`=0, `done`=0, `sample_strb`=0, `shift_strb`=0; state IDLE; all counters 0.
- `start` sampled high at edge T0 → `busy`=1 from T0.
- Edge k (k = 1…2N) appears at T0 + k·(D+1), where D=`div_q` and N=`num_bits_q`. `sck` and the matching strobe change on that same `clk` edge.
- Last `sck` edge is at T0 + 2N(D+1). `busy` falls and `done` pulses at T0 + (2N+1)(D+1).
- SCK period is 2(D+1) `clk` cycles. D=0 gives `clk`/2, with a strobe every cycle.
- A new `start` can be accepted in the cycle `done`=1, which is back-to-back with no idle gap.
- `abort` sampled at edge Ta → `busy`=0 after Ta; an edge that would have occurred at Ta is suppressed.

## Test plan
- Mode 0, `div`=3, `num_bits`=8, start at T0:
  - `sck` rises at T0+4, falls at T0+8, … 16 edges, last at T0+64.
  - 8 `sample_strb` on rises, 8 `shift_strb` on falls.
  - `done` at T0+68; `busy` high for exactly 68 cycles.
- Mode 3 (`cpol`=1, `cpha`=1), `div`=0, `num_bits`=4:
  - `sck` idles 1; first edge falling at T0+1 with `shift_strb`; `sample_strb` on rising edges.
  - `done` at T0+9; `sck`=1 afterwards.
- `div`=255, `num_bits`=31 (maximum values): 62 edges spaced 256 cycles apart; `done` at T0+63·256=T0+16128; no counter wrap.
- `abort` at T0+10 during mode 0, `div`=3, `num_bits`=8:
  - `busy`=0 and `sck`=0 from T0+10; no `done`; no strobes after T0+8.
  - A new `start` is then accepted normally.
- `start` with `num_bits`=0 → `busy` stays 0.
- `start` asserted again mid-transfer → ignored; total edge count unchanged.
- Back-to-back: `start` held high continuously, `div`=1, `num_bits`=2 → second transfer accepted in the `done` cycle, with identical edge timing relative to its own accept.
- `rst` asserted mid-RUN → next cycle all outputs at reset values; `cpol` input then reflected on `sck` one cycle after `rst` deasserts.
